// File: rtl/alu_issue_controller.sv
// alu_issue_controller: issues one ALU operation at a time, reads operands, writes back and reports completion.
package definitions;
    localparam int DATA_WIDTH = 32;
    localparam int FUNC_WIDTH = 4;
    localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = 4'd0;
    localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = 4'd1;
    localparam logic [FUNC_WIDTH-1:0] FUNC_AND = 4'd2;
    localparam logic [FUNC_WIDTH-1:0] FUNC_OR  = 4'd3;
    localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = 4'd4;
    localparam logic [FUNC_WIDTH-1:0] FUNC_EQL = 4'd5;
    localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = 4'd6;
endpackage

module alu_issue_controller #(
    parameter int DATA_WIDTH     = definitions::DATA_WIDTH,
    parameter int FUNC_WIDTH     = definitions::FUNC_WIDTH,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic                      _reqValid,
    output logic                      reqReady,
    input  logic [FUNC_WIDTH-1:0]     _reqFunc,
    input  logic [REG_ADDR_WIDTH-1:0] _reqSrcA,
    input  logic [REG_ADDR_WIDTH-1:0] _reqSrcB,
    input  logic [REG_ADDR_WIDTH-1:0] _reqDst,
    input  logic                      _reqUseImm,
    input  logic [DATA_WIDTH-1:0]     _reqImm,
    output logic [REG_ADDR_WIDTH-1:0] regReadAddrA,
    output logic [REG_ADDR_WIDTH-1:0] regReadAddrB,
    input  logic [DATA_WIDTH-1:0]     _regReadDataA,
    input  logic [DATA_WIDTH-1:0]     _regReadDataB,
    output logic                      regWriteEnable,
    output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
    output logic [DATA_WIDTH-1:0]     regWriteData,
    output logic [DATA_WIDTH-1:0]     aluValA,
    output logic [DATA_WIDTH-1:0]     aluValB,
    output logic [FUNC_WIDTH-1:0]     aluFuncCode,
    input  logic [DATA_WIDTH-1:0]     _aluResult,
    input  logic                      _aluOverflow,
    input  logic                      _aluCompareBit,
    output logic                      doneValid,
    input  logic                      _doneReady,
    output logic [DATA_WIDTH-1:0]     doneResult,
    output logic                      doneOverflow,
    output logic                      doneCompare,
    output logic                      compareFlag,
    output logic                      overflowSticky,
    input  logic                      _clearSticky
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
    state_t state, nextState;
    logic [FUNC_WIDTH-1:0]     func;
    logic [REG_ADDR_WIDTH-1:0] srcA, srcB, dst;
    logic                      useImm;
    logic [DATA_WIDTH-1:0]     imm, opA, opB, result;
    logic                      ovf, cmp, isCompare;

    always_ff @(posedge _clock or posedge _reset)
        if (_reset) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state == IDLE  ? (_reqValid ? READ : IDLE) :
                    state == READ  ? EXEC :
                    state == EXEC  ? WRITE :
                    state == WRITE ? DONE :
                    (_doneReady ? IDLE : DONE);
        reqReady = state == IDLE && !_reset;
        regWriteEnable = state == WRITE;
        doneValid = state == DONE;
    end

    assign isCompare = func == FUNC_WIDTH'(definitions::FUNC_LSS) ||
                       func == FUNC_WIDTH'(definitions::FUNC_EQL) ||
                       func == FUNC_WIDTH'(definitions::FUNC_GRT);

    always_ff @(posedge _clock or posedge _reset)
        if (_reset) begin
            func <= '0;
            srcA <= '0;
            srcB <= '0;
            dst <= '0;
            useImm <= 1'b0;
            imm <= '0;
            opA <= '0;
            opB <= '0;
            result <= '0;
            ovf <= 1'b0;
            cmp <= 1'b0;
            compareFlag <= 1'b0;
            overflowSticky <= 1'b0;
        end else begin
            if (state == IDLE && _reqValid) begin
                func <= _reqFunc;
                srcA <= _reqSrcA;
                srcB <= _reqSrcB;
                dst <= _reqDst;
                useImm <= _reqUseImm;
                imm <= _reqImm;
            end
            if (state == READ) begin
                opA <= _regReadDataA;
                opB <= useImm ? imm : _regReadDataB;
            end
            if (state == EXEC) begin
                result <= _aluResult;
                ovf <= _aluOverflow;
                cmp <= _aluCompareBit;
            end
            if (state == WRITE && isCompare) compareFlag <= cmp;
            // an overflowing write-back beats a simultaneous clear
            overflowSticky <= (state == WRITE && ovf) || (overflowSticky && !_clearSticky);
        end

    assign regReadAddrA = srcA;
    assign regReadAddrB = srcB;
    assign aluValA      = opA;
    assign aluValB      = opB;
    assign aluFuncCode  = func;
    assign regWriteAddr = dst;
    assign regWriteData = result;
    assign doneResult   = result;
    assign doneOverflow = ovf;
    assign doneCompare  = cmp;
endmodule

// File: tb/tb_alu_issue_controller.sv
// tb_alu_issue_controller: vector table plus scoreboard around a register-file and ALU model.
module tb_alu_issue_controller;
    typedef struct {
        logic [3:0]  func;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [3:0]  dst;
        logic        useImm;
        logic [31:0] imm;
        logic [31:0] res;
        logic        ovf;
        logic        cmp;
        logic        flag;
        logic        sticky;
        int          hold;
        logic        clrAtWrite;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, rfInit = 1'b0;
    logic reqValid = 1'b0, reqReady, reqUseImm = 1'b0, doneReady = 1'b0, clearSticky = 1'b0;
    logic [3:0] reqFunc = '0, reqSrcA = '0, reqSrcB = '0, reqDst = '0;
    logic [31:0] reqImm = '0;
    logic [3:0] regReadAddrA, regReadAddrB, regWriteAddr, aluFuncCode;
    logic [31:0] regReadDataA, regReadDataB, regWriteData, aluValA, aluValB, aluRes, doneResult;
    logic regWriteEnable, aluOvf, aluCmp, doneValid, doneOverflow, doneCompare, compareFlag, overflowSticky;
    logic [31:0] rf [16];
    logic [31:0] sum, diff;
    vec_t vecs [9];
    vec_t sbQ [$];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    alu_issue_controller dut (
        ._clock(clk), ._reset(rst), ._reqValid(reqValid), .reqReady(reqReady),
        ._reqFunc(reqFunc), ._reqSrcA(reqSrcA), ._reqSrcB(reqSrcB), ._reqDst(reqDst),
        ._reqUseImm(reqUseImm), ._reqImm(reqImm),
        .regReadAddrA(regReadAddrA), .regReadAddrB(regReadAddrB),
        ._regReadDataA(regReadDataA), ._regReadDataB(regReadDataB),
        .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .aluValA(aluValA), .aluValB(aluValB), .aluFuncCode(aluFuncCode),
        ._aluResult(aluRes), ._aluOverflow(aluOvf), ._aluCompareBit(aluCmp),
        .doneValid(doneValid), ._doneReady(doneReady), .doneResult(doneResult),
        .doneOverflow(doneOverflow), .doneCompare(doneCompare),
        .compareFlag(compareFlag), .overflowSticky(overflowSticky), ._clearSticky(clearSticky)
    );

    always @(posedge clk)
        if (rfInit) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[1] <= 32'd5;
            rf[2] <= 32'd7;
            rf[4] <= 32'd3;
            rf[5] <= 32'h7FFF_FFFF;
            rf[6] <= 32'hFFFF_FFFF;
            rf[7] <= 32'd1;
        end else if (regWriteEnable) rf[regWriteAddr] <= regWriteData;

    assign regReadDataA = rf[regReadAddrA];
    assign regReadDataB = rf[regReadAddrB];
    assign sum = aluValA + aluValB;
    assign diff = aluValA - aluValB;

    always_comb begin
        aluRes = 32'd0;
        aluOvf = 1'b0;
        aluCmp = 1'b0;
        case (aluFuncCode)
            definitions::FUNC_ADD: begin
                aluRes = sum;
                aluOvf = aluValA[31] == aluValB[31] && sum[31] != aluValA[31];
            end
            definitions::FUNC_SUB: begin
                aluRes = diff;
                aluOvf = aluValA[31] != aluValB[31] && diff[31] != aluValA[31];
            end
            definitions::FUNC_AND: aluRes = aluValA & aluValB;
            definitions::FUNC_OR:  aluRes = aluValA | aluValB;
            definitions::FUNC_LSS: begin
                aluCmp = $signed(aluValA) < $signed(aluValB);
                aluRes = {31'd0, aluCmp};
            end
            definitions::FUNC_EQL: begin
                aluCmp = aluValA == aluValB;
                aluRes = {31'd0, aluCmp};
            end
            definitions::FUNC_GRT: begin
                aluCmp = $signed(aluValA) > $signed(aluValB);
                aluRes = {31'd0, aluCmp};
            end
            default: aluRes = 32'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input vec_t v);
        int cyc;
        bit wrSeen;
        vec_t e;
        check("reqReadyIdle", reqReady, 1);
        reqValid = 1'b1;
        reqFunc = v.func;
        reqSrcA = v.srcA;
        reqSrcB = v.srcB;
        reqDst = v.dst;
        reqUseImm = v.useImm;
        reqImm = v.imm;
        tick();
        reqValid = 1'b0;
        sbQ.push_back(v);
        cyc = 1;
        wrSeen = 1'b0;
        while (!doneValid && cyc < 12) begin
            if (v.clrAtWrite && cyc == 3) clearSticky = 1'b1;
            if (regWriteEnable) begin
                check("wrCycle", cyc, 3);
                check("wrAddr", {28'd0, regWriteAddr}, {28'd0, v.dst});
                check("wrData", regWriteData, v.res);
                wrSeen = 1'b1;
            end
            tick();
            clearSticky = 1'b0;
            cyc++;
        end
        check("wrSeen", {31'd0, wrSeen}, 1);
        check("doneValid", {31'd0, doneValid}, 1);
        check("doneCycle", cyc, 4);
        e = sbQ.pop_front();
        check("doneResult", doneResult, e.res);
        check("doneOverflow", {31'd0, doneOverflow}, {31'd0, e.ovf});
        check("doneCompare", {31'd0, doneCompare}, {31'd0, e.cmp});
        check("compareFlag", {31'd0, compareFlag}, {31'd0, e.flag});
        check("overflowSticky", {31'd0, overflowSticky}, {31'd0, e.sticky});
        check("wrOffInDone", {31'd0, regWriteEnable}, 0);
        check("rfWritten", rf[e.dst], e.res);
        for (int i = 0; i < e.hold; i++) begin
            reqValid = 1'b1;
            reqDst = 4'd15;
            tick();
            check("holdValid", {31'd0, doneValid}, 1);
            check("holdResult", doneResult, e.res);
            check("holdReqReady", {31'd0, reqReady}, 0);
        end
        doneReady = 1'b1;
        tick();
        doneReady = 1'b0;
        check("readyAfterHandshake", {31'd0, reqReady}, 1);
        check("doneDropped", {31'd0, doneValid}, 0);
        reqValid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{definitions::FUNC_ADD, 4'd1, 4'd2, 4'd3,  1'b0, 32'd0, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        vecs[1] = '{definitions::FUNC_ADD, 4'd5, 4'd0, 4'd8,  1'b1, 32'd1, 32'h8000_0000,  1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[2] = '{definitions::FUNC_LSS, 4'd6, 4'd7, 4'd9,  1'b0, 32'd0, 32'd1,          1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[3] = '{definitions::FUNC_AND, 4'd6, 4'd7, 4'd10, 1'b0, 32'd0, 32'd1,          1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vecs[4] = '{definitions::FUNC_GRT, 4'd6, 4'd7, 4'd11, 1'b0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{definitions::FUNC_SUB, 4'd4, 4'd4, 4'd4,  1'b0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[6] = '{definitions::FUNC_EQL, 4'd1, 4'd0, 4'd12, 1'b1, 32'd5, 32'd1,          1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vecs[7] = '{definitions::FUNC_ADD, 4'd5, 4'd0, 4'd14, 1'b1, 32'd1, 32'h8000_0000,  1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1};
        vecs[8] = '{definitions::FUNC_ADD, 4'd1, 4'd2, 4'd13, 1'b0, 32'd0, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        rfInit = 1'b1;
        tick();
        rfInit = 1'b0;
        check("rstReqReady", {31'd0, reqReady}, 0);
        check("rstDoneValid", {31'd0, doneValid}, 0);
        check("rstWrite", {31'd0, regWriteEnable}, 0);
        check("rstAluA", aluValA, 0);
        check("rstReadAddr", {28'd0, regReadAddrA}, 0);
        check("rstFlags", {30'd0, compareFlag, overflowSticky}, 0);
        rst = 1'b0;
        #1;
        check("releaseReqReady", {31'd0, reqReady}, 1);
        runOp(vecs[0]);
        runOp(vecs[1]);
        clearSticky = 1'b1;
        tick();
        clearSticky = 1'b0;
        check("stickyCleared", {31'd0, overflowSticky}, 0);
        for (int i = 2; i < 8; i++) runOp(vecs[i]);
        reqValid = 1'b1;
        reqFunc = definitions::FUNC_ADD;
        reqSrcA = 4'd1;
        reqSrcB = 4'd2;
        reqDst = 4'd15;
        reqUseImm = 1'b0;
        tick();
        reqValid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midRstWrite", {31'd0, regWriteEnable}, 0);
        check("midRstDone", {31'd0, doneValid}, 0);
        check("midRstFlags", {30'd0, compareFlag, overflowSticky}, 0);
        check("midRstReqReady", {31'd0, reqReady}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midRstNoWrite", {31'd0, regWriteEnable}, 0);
        end
        rst = 1'b0;
        #1;
        check("midRstDropped", rf[15], 0);
        check("midRstIdle", {31'd0, reqReady}, 1);
        runOp(vecs[8]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_issue_controller.md
# alu_issue_controller

Multi-cycle issue/write-back controller that sits upstream and downstream of the arithmetic logic unit. It accepts one operation request at a time, fetches operands from the register file and drives the ALU's value, function-code and operand inputs. It then captures the ALU's result, overflow and compare outputs, writes the result back to the register file, and reports completion through a valid/ready handshake. It also maintains the architectural compare flag and a sticky overflow status bit.

## Interface

Parameters:
- DATA_WIDTH, definitions::DATA_WIDTH: operand/result width.
- FUNC_WIDTH, definitions::FUNC_WIDTH: ALU function-code width.
- REG_ADDR_WIDTH, 4: register-file index width.

Ports:
- _clock, input, 1: single clock; all state changes on rising edge.
- _reset, input, 1: asynchronous, active-high reset.
- _reqValid, input, 1: request present.
- reqReady, output, 1: controller can accept a request.
- _reqFunc, input, FUNC_WIDTH: ALU function code.
- _reqSrcA, input, REG_ADDR_WIDTH: source A register index.
- _reqSrcB, input, REG_ADDR_WIDTH: source B register index.
- _reqDst, input, REG_ADDR_WIDTH: destination register index.
- _reqUseImm, input, 1: operand B comes from _reqImm instead of register B.
- _reqImm, input, DATA_WIDTH: immediate operand.
- regReadAddrA, output, REG_ADDR_WIDTH: register-file read index A.
- regReadAddrB, output, REG_ADDR_WIDTH: register-file read index B.
- _regReadDataA, input, DATA_WIDTH: combinational read data for index A.
- _regReadDataB, input, DATA_WIDTH: combinational read data for index B.
- regWriteEnable, output, 1: one-cycle write strobe.
- regWriteAddr, output, REG_ADDR_WIDTH: write index.
- regWriteData, output, DATA_WIDTH: write data.
- aluValA, output, DATA_WIDTH: ALU operand A.
- aluValB, output, DATA_WIDTH: ALU operand B.
- aluFuncCode, output, FUNC_WIDTH: ALU function code.
- _aluResult, input, DATA_WIDTH: ALU result.
- _aluOverflow, input, 1: ALU overflow output.
- _aluCompareBit, input, 1: ALU compare output.
- doneValid, output, 1: completion record valid.
- _doneReady, input, 1: consumer accepts the completion record.
- doneResult, output, DATA_WIDTH: completed result.
- doneOverflow, output, 1: overflow of the completed operation.
- doneCompare, output, 1: compare bit of the completed operation.
- compareFlag, output, 1: architectural compare flag.
- overflowSticky, output, 1: sticky overflow flag.
- _clearSticky, input, 1: synchronous clear of overflowSticky.

## Operation

States are IDLE, READ, EXEC, WRITE and DONE.

- **IDLE:** reqReady=1. On _reqValid & reqReady, latch func, srcA, srcB, dst, useImm and imm, then go to READ. Requests are ignored in every other state.
- **READ:** regReadAddrA/B = latched srcA/srcB. Latch operand A = _regReadDataA. Latch operand B = useImm ? imm : _regReadDataB. Go to EXEC.
- **EXEC:** aluValA/aluValB/aluFuncCode = latched operands and func. Latch _aluResult, _aluOverflow and _aluCompareBit. Go to WRITE.
- **WRITE:**
  - regWriteEnable=1, regWriteAddr=dst, regWriteData=latched result.
  - compareFlag updates to the latched compare bit only when func is FUNC_LSS, FUNC_EQL or FUNC_GRT; other functions leave it unchanged.
  - overflowSticky is set if the latched overflow is 1.
  - Go to DONE.
- **DONE:** doneValid=1 with doneResult/doneOverflow/doneCompare stable. On _doneReady, go to IDLE.

Other behaviour:
- The write is performed even when overflow=1; overflow is reported, never suppressed.
- _clearSticky clears overflowSticky in any state. If it coincides with a WRITE that sets the flag, the set wins.
- ALU and read-address outputs hold their last latched values outside READ/EXEC.
- Source and destination may be the same index. Operands are read before the write, so no hazard exists.

## Timing

- Accept edge T: READ in cycle T+1, EXEC T+2, WRITE T+3 (regWriteEnable high exactly one cycle), doneValid from T+4.
- Throughput is one request per 5 cycles when _doneReady is held 1. reqReady rises in the cycle after the done handshake.
- regWriteEnable is never high outside WRITE.
- doneValid stays asserted and its data stays stable until the _doneReady handshake.
- Reset values: reqReady=0 while _reset is high, 1 after release (IDLE). All other outputs are 0, including compareFlag, overflowSticky, regWriteEnable, doneValid, ALU outputs and read addresses.
- Reset mid-operation returns to IDLE immediately. No write-back occurs and the in-flight request is dropped.

## Test plan

- **ADD:** r1=5, r2=7, ADD dst=r3 → regWriteEnable at T+3 with addr 3, data 12. doneValid at T+4 with doneResult=12, doneOverflow=0.
- **Overflow:** r1=0x7FFFFFFF, immediate 1, ADD → result 0x80000000, doneOverflow=1, overflowSticky=1. A later _clearSticky pulse → 0. A _clearSticky pulse concurrent with an overflowing WRITE → flag stays 1.
- **Compare:** r1=-1, r2=1, LSS → compareFlag=1, regWriteData=1. Then AND → compareFlag remains 1. Then GRT with the same operands → compareFlag=0.
- **Backpressure:** hold _doneReady=0 for 3 cycles → doneValid and doneResult stable, reqReady=0, and a second request is not accepted until the cycle after the handshake.
- **Reset during EXEC:** assert _reset → no regWriteEnable, doneValid=0, flags=0. After release, the next request completes normally.
- **Same-register operands:** srcA=srcB=dst=r4 holding 3, SUB → r4 written 0.
